mmio_uart_bridge: RTL

MMIO_UART_BRIDGE -- requirements
Module: mmio_uart_bridge

---
 rtl/io_map_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 38 +++
 rtl/mmio_uart_bridge.sv | 83 ++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: shared region codes, IO register offsets and status bit positions
package io_map_pkg;
  typedef enum logic [1:0] {RGN_NONE, RGN_DMEM, RGN_IMEM, RGN_IO} region_e;
  localparam logic [3:0] IO_BASE = 4'h8;
  localparam logic [4:0] OFF_TX_STAT = 5'h00;
  localparam logic [4:0] OFF_RX_STAT = 5'h04;
  localparam logic [4:0] OFF_TX_DATA = 5'h08;
  localparam logic [4:0] OFF_RX_DATA = 5'h0C;
  localparam logic [4:0] OFF_CYCLE   = 5'h10;
  localparam logic [4:0] OFF_INSTR   = 5'h14;
  localparam logic [4:0] OFF_CNT_CLR = 5'h18;
  localparam logic [4:0] OFF_STATUS  = 5'h1C;
  localparam int ST_TX_OVF = 0;
  localparam int ST_RX_UDF = 1;
  // DMEM wins over IMEM when both low-order region bits are set
  function automatic region_e decode_region(input logic [3:0] a);
    return a[3] ? ((a == IO_BASE) ? RGN_IO : RGN_NONE) :
           a[0] ? RGN_DMEM : a[1] ? RGN_IMEM : RGN_NONE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pushes when full and pops when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/mmio_uart_bridge.sv
// mmio_uart_bridge: memory-stage address decode plus UART FIFOs, counters and status
module mmio_uart_bridge
  import io_map_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MemAddr,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [3:0]  StoreMask,
  input  logic [31:0] StoreData,
  input  logic        InstrRetired,
  output logic [3:0]  StoreMaskDMEM,
  output logic [3:0]  StoreMaskIMEM,
  output logic        LoadSelIO,
  output logic [31:0] IoRdData,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady
);
  localparam int QW = $clog2(FIFO_DEPTH) + 1;
  region_e rgn;
  logic [4:0] off;
  logic io_rd, io_wr, tx_push, rx_pop, cnt_clr, w1c;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_udf;
  logic [QW-1:0] tx_count, rx_count;
  logic [7:0] rx_head;
  logic [CNT_W-1:0] cyc, ins;
  logic [31:0] rd_val;
  logic unused_bits;
  assign unused_bits = ^{MemAddr[27:5], StoreData[31:8]};
  assign rgn = decode_region(MemAddr[31:28]);
  assign off = MemAddr[4:0];
  assign StoreMaskDMEM = (MemWrite && rgn == RGN_DMEM) ? StoreMask : 4'b0000;
  assign StoreMaskIMEM = (MemWrite && rgn == RGN_IMEM) ? StoreMask : 4'b0000;
  assign io_rd = MemRead && rgn == RGN_IO;
  assign io_wr = MemWrite && rgn == RGN_IO;
  assign tx_push = io_wr && off == OFF_TX_DATA;
  assign rx_pop = io_rd && off == OFF_RX_DATA;
  assign cnt_clr = io_wr && off == OFF_CNT_CLR;
  assign w1c = io_wr && off == OFF_STATUS;
  assign TxValid = !tx_empty;
  assign RxReady = !rx_full;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(StoreData[7:0]),
    .pop(TxValid && TxReady), .dout(TxData), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n), .push(RxValid && RxReady), .din(RxData),
    .pop(rx_pop), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  always_comb
    rd_val = (off == OFF_TX_STAT) ? {31'b0, !tx_full} :
             (off == OFF_RX_STAT) ? {31'b0, !rx_empty} :
             (off == OFF_RX_DATA) ? (rx_empty ? 32'b0 : {24'b0, rx_head}) :
             (off == OFF_CYCLE)   ? 32'(cyc) :
             (off == OFF_INSTR)   ? 32'(ins) :
             (off == OFF_STATUS)  ? {8'b0, 8'(rx_count), 8'(tx_count), 6'b0, rx_udf, tx_ovf} :
             32'b0;
  // sticky flags take this cycle's set first, then a same-cycle W1C wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      LoadSelIO <= 1'b0;
      IoRdData <= '0;
      cyc <= '0;
      ins <= '0;
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      LoadSelIO <= io_rd;
      if (io_rd) IoRdData <= rd_val;
      cyc <= cnt_clr ? '0 : cyc + CNT_W'(1);
      ins <= cnt_clr ? '0 : ins + CNT_W'(InstrRetired);
      tx_ovf <= (tx_ovf | (tx_push && tx_full)) & !(w1c && StoreData[ST_TX_OVF]);
      rx_udf <= (rx_udf | (rx_pop && rx_empty)) & !(w1c && StoreData[ST_RX_UDF]);
    end
endmodule
